// File: rtl/simon_autoplayer.sv
// Automated Simon player: drives Simon's switches and user clock the way a person
// would, keeps its own copy of the inserted patterns and checks every playback entry.
module simon_autoplayer #(
    parameter int         DEPTH  = 64,
    parameter int         SETTLE = 2,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       level_sel,
    input  logic       fail_en,
    input  logic [5:0] fail_round,
    input  logic [2:0] mode_leds,
    input  logic [3:0] pattern_leds,
    output logic [3:0] pattern,
    output logic       level,
    output logic       sim_rst,
    output logic       step,
    output logic [6:0] round,
    output logic       busy,
    output logic       won,
    output logic       lost,
    output logic       err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_SIM, S_CHECK, S_INSERT, S_PLAY, S_REPEAT, S_FINISH
    } state_t;

    typedef enum logic [1:0] {F_RESET, F_INSERT, F_PLAY, F_REPEAT} from_t;

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(2 * SETTLE + 2);
    localparam logic [CNT_W-1:0] STEP_AT = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] SEQ_END = CNT_W'(2 * SETTLE + 1);
    localparam logic [6:0]       DEPTH_C = 7'(DEPTH);

    // Handshake with Simon: a step sequence holds pattern/level/sim_rst stable for
    // SETTLE cycles, pulses step for one cycle, then waits SETTLE cycles before sampling.
    state_t           state_q, state_d;
    from_t            from_q, from_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       idx_q, idx_d, count_q, count_d, round_q, round_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [3:0]       pattern_q, pattern_d;
    logic             level_q, level_d, sim_rst_q, sim_rst_d, step_q, step_d;
    logic             busy_q, busy_d, won_q, won_d, lost_q, lost_d, err_q, err_d;
    logic             fail_en_q, fail_en_d;
    logic [5:0]       fail_round_q, fail_round_d;

    logic [3:0] hist_q [DEPTH];
    logic       hist_we;
    logic [3:0] hist_rd, gen_pat;
    logic [7:0] lfsr_nxt;
    logic       last_idx, corrupt_round;

    assign lfsr_nxt      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign gen_pat       = level_q ? ((lfsr_q[3:0] == 4'd0) ? 4'hF : lfsr_q[3:0])
                                   : (4'b0001 << lfsr_q[1:0]);
    assign hist_rd       = hist_q[idx_q[AW-1:0]];
    assign last_idx      = (idx_q == count_q - 7'd1);
    assign corrupt_round = fail_en_q && (round_q == {1'b0, fail_round_q});

    always_comb begin
        state_d      = state_q;
        from_d       = from_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        count_d      = count_q;
        round_d      = round_q;
        lfsr_d       = lfsr_q;
        pattern_d    = pattern_q;
        level_d      = level_q;
        sim_rst_d    = sim_rst_q;
        step_d       = 1'b0;
        busy_d       = busy_q;
        won_d        = won_q;
        lost_d       = lost_q;
        err_d        = err_q;
        fail_en_d    = fail_en_q;
        fail_round_d = fail_round_q;
        hist_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    level_d      = level_sel;
                    fail_en_d    = fail_en;
                    fail_round_d = fail_round;
                    won_d        = 1'b0;
                    lost_d       = 1'b0;
                    err_d        = 1'b0;
                    round_d      = 7'd0;
                    count_d      = 7'd0;
                    busy_d       = 1'b1;
                    sim_rst_d    = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_RESET_SIM;
                end
            end
            S_RESET_SIM: begin
                cnt_d  = cnt_q + 1'b1;
                step_d = (cnt_q == STEP_AT);
                if (cnt_q == SEQ_END) begin
                    sim_rst_d = 1'b0;
                    from_d    = F_RESET;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d   = '0;
                idx_d   = 7'd0;
                err_d   = 1'b1;
                state_d = S_FINISH;
                case (from_q)
                    F_RESET: if (mode_leds == 3'b001) begin
                        err_d = 1'b0; state_d = S_INSERT;
                    end
                    F_INSERT: if (mode_leds == 3'b010) begin
                        err_d = 1'b0; state_d = S_PLAY;
                    end
                    F_PLAY: if (mode_leds == 3'b100) begin
                        err_d = 1'b0; state_d = S_REPEAT;
                    end
                    default: begin
                        if (corrupt_round) begin
                            if (mode_leds == 3'b111) begin
                                err_d  = 1'b0;
                                lost_d = 1'b1;
                            end
                        end else if (mode_leds == 3'b001) begin
                            err_d   = 1'b0;
                            round_d = round_q + 7'd1;
                            if (round_q + 7'd1 == DEPTH_C) won_d = 1'b1;
                            else state_d = S_INSERT;
                        end
                    end
                endcase
            end
            S_INSERT: begin
                cnt_d  = cnt_q + 1'b1;
                step_d = (cnt_q == STEP_AT);
                if (cnt_q == '0) begin
                    pattern_d = gen_pat;
                    hist_we   = 1'b1;
                    count_d   = count_q + 7'd1;
                    lfsr_d    = lfsr_nxt;
                end
                if (cnt_q == SEQ_END) begin
                    from_d  = F_INSERT;
                    state_d = S_CHECK;
                end
            end
            S_PLAY: begin
                cnt_d  = cnt_q + 1'b1;
                step_d = (cnt_q == STEP_AT);
                if (cnt_q == '0 && pattern_leds != hist_rd) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (cnt_q == SEQ_END) begin
                    idx_d = idx_q + 7'd1;
                    cnt_d = '0;
                    if (last_idx) begin
                        from_d  = F_PLAY;
                        state_d = S_CHECK;
                    end
                end
            end
            S_REPEAT: begin
                cnt_d  = cnt_q + 1'b1;
                step_d = (cnt_q == STEP_AT);
                if (cnt_q == '0) begin
                    if (idx_q != 7'd0 && mode_leds != 3'b100) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        pattern_d = (corrupt_round && last_idx) ? ~hist_rd : hist_rd;
                    end
                end else if (cnt_q == SEQ_END) begin
                    idx_d = idx_q + 7'd1;
                    cnt_d = '0;
                    if (last_idx) begin
                        from_d  = F_REPEAT;
                        state_d = S_CHECK;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            from_q       <= F_RESET;
            cnt_q        <= '0;
            idx_q        <= 7'd0;
            count_q      <= 7'd0;
            round_q      <= 7'd0;
            lfsr_q       <= SEED;
            pattern_q    <= 4'd0;
            level_q      <= 1'b0;
            sim_rst_q    <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            err_q        <= 1'b0;
            fail_en_q    <= 1'b0;
            fail_round_q <= 6'd0;
        end else begin
            state_q      <= state_d;
            from_q       <= from_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            round_q      <= round_d;
            lfsr_q       <= lfsr_d;
            pattern_q    <= pattern_d;
            level_q      <= level_d;
            sim_rst_q    <= sim_rst_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
            err_q        <= err_d;
            fail_en_q    <= fail_en_d;
            fail_round_q <= fail_round_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (hist_we) hist_q[count_q[AW-1:0]] <= gen_pat;
    end

    assign pattern   = pattern_q;
    assign level     = level_q;
    assign sim_rst   = sim_rst_q;
    assign step      = step_q;
    assign round     = round_q;
    assign busy      = busy_q;
    assign won       = won_q;
    assign lost      = lost_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer paired with a behavioural Simon clocked by step.
module tb_simon_autoplayer;
    localparam int         DEPTH  = 4;
    localparam int         SETTLE = 2;
    localparam logic [7:0] SEED   = 8'hA5;

    logic       pclk = 1'b0;
    logic       rst, start, level_sel, fail_en;
    logic [5:0] fail_round;
    logic [2:0] mode_leds;
    logic [3:0] pattern_leds, pattern;
    logic       level, sim_rst, step, busy, won, lost, err;
    logic [6:0] round;
    logic [2:0] dbg_state;

    simon_autoplayer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .SEED(SEED)) dut (
        .pclk(pclk), .rst(rst), .start(start), .level_sel(level_sel),
        .fail_en(fail_en), .fail_round(fail_round), .mode_leds(mode_leds),
        .pattern_leds(pattern_leds), .pattern(pattern), .level(level),
        .sim_rst(sim_rst), .step(step), .round(round), .busy(busy),
        .won(won), .lost(lost), .err(err), .dbg_state(dbg_state)
    );

    always #5 pclk = ~pclk;

    int pass_cnt = 0, total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural Simon: 001 input, 010 playback, 100 repeat, 111 done
    logic [2:0] s_mode = 3'b000;
    logic [3:0] s_mem [64];
    logic [6:0] s_cnt = 7'd0, s_pidx = 7'd0;
    logic       inj_en = 1'b0;
    logic [3:0] ins_q [$];

    always @(posedge step or posedge sim_rst) begin
        if (sim_rst) begin
            s_mode <= 3'b001;
            s_cnt  <= 7'd0;
            s_pidx <= 7'd0;
        end else begin
            case (s_mode)
                3'b001: begin
                    s_mem[s_cnt[5:0]] <= pattern;
                    ins_q.push_back(pattern);
                    s_cnt  <= s_cnt + 7'd1;
                    s_pidx <= 7'd0;
                    s_mode <= 3'b010;
                end
                3'b010: begin
                    if (s_pidx + 7'd1 == s_cnt) begin
                        s_pidx <= 7'd0;
                        s_mode <= 3'b100;
                    end else s_pidx <= s_pidx + 7'd1;
                end
                3'b100: begin
                    if (pattern != s_mem[s_pidx[5:0]]) s_mode <= 3'b111;
                    else if (s_pidx + 7'd1 == s_cnt) begin
                        s_pidx <= 7'd0;
                        s_mode <= 3'b001;
                    end else s_pidx <= s_pidx + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign mode_leds    = s_mode;
    assign pattern_leds = (s_mode == 3'b010)
                        ? (s_mem[s_pidx[5:0]] ^ ((inj_en && s_cnt == 7'd2 && s_pidx == 7'd1) ? 4'h8 : 4'h0))
                        : 4'h0;

    // Protocol monitors: step spacing, input stability around step, round history
    int         cyc = 0, last_step = -1000, last_chg = -1000;
    int         stab_viol = 0, consec_viol = 0, step_cnt = 0, steps_at_err = 0, simrst_rise = 0;
    int         lvl_bad = 0;
    logic [5:0] prev_out = 6'd0;
    logic       prev_step = 1'b0, prev_simrst = 1'b0;
    logic [6:0] prev_round = 7'd0;
    logic [6:0] obs_round_q [$];
    logic [6:0] exp_q [$];

    always @(negedge pclk) begin
        cyc++;
        if (rst) begin
            last_step = -1000;
            last_chg  = -1000;
        end else begin
            if ({pattern, level, sim_rst} != prev_out) begin
                if (cyc - last_step <= SETTLE) stab_viol++;
                last_chg = cyc;
            end
            if (step) begin
                if (cyc - last_chg < SETTLE) stab_viol++;
                if (prev_step) consec_viol++;
                step_cnt++;
                last_step = cyc;
            end
            if (sim_rst && !prev_simrst) simrst_rise++;
        end
        prev_out    = {pattern, level, sim_rst};
        prev_step   = step;
        prev_simrst = sim_rst;
        if (round !== prev_round) begin
            obs_round_q.push_back(round);
            prev_round = round;
        end
    end

    always @(posedge err) steps_at_err = step_cnt;

    logic [7:0] model_lfsr = SEED;
    logic       zero_seen  = 1'b0;

    function automatic logic [3:0] gen_pat(input logic lvl, input logic [7:0] l);
        if (lvl) return (l[3:0] == 4'd0) ? 4'hF : l[3:0];
        return 4'b0001 << l[1:0];
    endfunction

    task automatic check_inserts(input logic lvl);
        logic [3:0] p;
        while (ins_q.size() > 0) begin
            p = ins_q.pop_front();
            check("insert_pattern", 32'(p), 32'(gen_pat(lvl, model_lfsr)));
            if (lvl) begin
                if (p == 4'd0) check("insert_nonzero", 32'(p), 32'hF);
                if (model_lfsr[3:0] == 4'd0) begin
                    zero_seen = 1'b1;
                    check("zero_nibble_map", 32'(p), 32'hF);
                end
            end
            model_lfsr = {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
        end
    endtask

    task automatic pulse_start(input logic lvl, input logic fen, input logic [5:0] fr);
        @(negedge pclk);
        level_sel  = lvl;
        fail_en    = fen;
        fail_round = fr;
        start      = 1'b1;
        @(negedge pclk);
        start      = 1'b0;
    endtask

    task automatic run_game(input logic lvl, input logic fen, input logic [5:0] fr);
        pulse_start(lvl, fen, fr);
        for (int i = 0; i < 5000; i++) begin
            if (!busy) break;
            if (level !== lvl) lvl_bad++;
            @(negedge pclk);
        end
        check("game_terminates", 32'(busy), 32'd0);
    endtask

    task automatic check_result(input logic ew, input logic el, input logic ee, input logic [6:0] er);
        check("won",   32'(won),   32'(ew));
        check("lost",  32'(lost),  32'(el));
        check("err",   32'(err),   32'(ee));
        check("round", 32'(round), 32'(er));
        check("busy",  32'(busy),  32'd0);
    endtask

    typedef struct {
        logic       lvl;
        logic       fen;
        logic [5:0] fr;
        logic       inj;
        logic       ewon;
        logic       elost;
        logic       eerr;
        logic [6:0] eround;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4};
        vecs[1] = '{1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, 7'd2};
        vecs[2] = '{1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd1};
        vecs[3] = '{1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4};
        vecs[4] = '{1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0};
        vecs[5] = '{1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 7'd3};
        vecs[6] = '{1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 7'd4};

        rst = 1'b1; start = 1'b0; level_sel = 1'b0; fail_en = 1'b0; fail_round = 6'd0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        check("rst_pattern", 32'(pattern),   32'd0);
        check("rst_level",   32'(level),     32'd0);
        check("rst_sim_rst", 32'(sim_rst),   32'd0);
        check("rst_step",    32'(step),      32'd0);
        check("rst_round",   32'(round),     32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_won",     32'(won),       32'd0);
        check("rst_lost",    32'(lost),      32'd0);
        check("rst_err",     32'(err),       32'd0);
        check("rst_state",   32'(dbg_state), 32'd0);

        // First game: known pattern sequence from SEED and round progression
        obs_round_q.delete();
        exp_q = '{7'd1, 7'd2, 7'd3, 7'd4};
        run_game(1'b0, 1'b0, 6'd0);
        check("sim_rst_pulses", 32'(simrst_rise), 32'd1);
        check("insert_count", 32'(ins_q.size()), 32'd4);
        if (ins_q.size() == 4) begin
            check("insert0", 32'(ins_q[0]), 32'h2);
            check("insert1", 32'(ins_q[1]), 32'h4);
            check("insert2", 32'(ins_q[2]), 32'h2);
            check("insert3", 32'(ins_q[3]), 32'h4);
        end
        check_inserts(1'b0);
        check_result(1'b1, 1'b0, 1'b0, 7'd4);
        check("round_hist_len", 32'(obs_round_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_round_q.size() > 0)
            check("round_hist", 32'(obs_round_q.pop_front()), 32'(exp_q.pop_front()));

        for (int v = 0; v < 7; v++) begin
            inj_en = vecs[v].inj;
            run_game(vecs[v].lvl, vecs[v].fen, vecs[v].fr);
            check_inserts(vecs[v].lvl);
            check_result(vecs[v].ewon, vecs[v].elost, vecs[v].eerr, vecs[v].eround);
            if (vecs[v].inj) begin
                repeat (40) @(negedge pclk);
                check("no_step_after_err", 32'(step_cnt), 32'(steps_at_err));
            end
            inj_en = 1'b0;
        end

        // start arriving in the FINISH cycle is dropped
        pulse_start(1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 5000; i++) begin
            if (dbg_state == 3'd6) break;
            @(negedge pclk);
        end
        check("reached_finish", 32'(dbg_state), 32'd6);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        repeat (3) @(negedge pclk);
        check("finish_start_ignored_busy",  32'(busy),      32'd0);
        check("finish_start_ignored_state", 32'(dbg_state), 32'd0);
        check_inserts(1'b0);

        // Level 1 games until an LFSR value with a zero low nibble gets inserted
        for (int g = 0; g < 70 && !zero_seen; g++) begin
            run_game(1'b1, 1'b0, 6'd0);
            check_inserts(1'b1);
            check("lvl1_won", 32'(won), 32'd1);
        end
        check("zero_nibble_seen", 32'(zero_seen), 32'd1);
        check("level_held", 32'(lvl_bad), 32'd0);

        // Reset in the middle of a PLAY phase, then replay from SEED
        pulse_start(1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 5000; i++) begin
            if (dbg_state == 3'd4 && round == 7'd1) break;
            @(negedge pclk);
        end
        check("reached_play", 32'(dbg_state), 32'd4);
        rst = 1'b1;
        #1;
        check("midrst_pattern", 32'(pattern), 32'd0);
        check("midrst_sim_rst", 32'(sim_rst), 32'd0);
        check("midrst_step",    32'(step),    32'd0);
        check("midrst_round",   32'(round),   32'd0);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_level",   32'(level),   32'd0);
        @(negedge pclk);
        rst = 1'b0;
        ins_q.delete();
        model_lfsr = SEED;
        run_game(1'b0, 1'b0, 6'd0);
        if (ins_q.size() >= 2) begin
            check("replay0", 32'(ins_q[0]), 32'h2);
            check("replay1", 32'(ins_q[1]), 32'h4);
        end else check("replay_count", 32'(ins_q.size()), 32'd4);
        check_inserts(1'b0);
        check_result(1'b1, 1'b0, 1'b0, 7'd4);

        check("step_not_consecutive", 32'(consec_viol), 32'd0);
        check("inputs_stable_around_step", 32'(stab_viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
